// File: rtl/serial_tx_controller.sv
// Byte FIFO feeding an 8N1 UART transmitter.
// Frames are sent LSB first, and the stop bit chains straight into the next start bit.
module serial_tx_controller #(
    parameter int SERIAL_OUTPUT_WIDTH = 8,
    parameter int FIFO_DEPTH          = 16,
    parameter int CLKS_PER_BIT        = 868
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          serialWE,
    input  logic [SERIAL_OUTPUT_WIDTH-1:0] serialWriteDataIn,
    input  logic                          clearOverflow,
    output logic                          txOut,
    output logic                          busy,
    output logic                          fifoFull,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
    output logic                          overflow
);

    localparam int W  = SERIAL_OUTPUT_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q;
    logic [W-1:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full_q;
    logic          ovf_q;
    logic [BW-1:0] baud_q;
    logic [IW-1:0] bit_q;
    logic [W-1:0]  shift_q;
    logic          tx_q;
    logic          busy_q;
    logic          push;
    logic          pop;
    logic          baud_end;
    logic [W-1:0]  head;

    assign baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign push     = serialWE && !full_q;
    assign head     = mem_q[rd_ptr_q];

    // Only the FSM consumes bytes: from IDLE, or at the end of a stop bit.
    always_comb begin
        pop = 1'b0;
        if (count_q != '0) begin
            if (state_q == IDLE)
                pop = 1'b1;
            else if (state_q == STOP && baud_end)
                pop = 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (!push && pop)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= serialWriteDataIn;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == CW'(FIFO_DEPTH));
            if (push)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            // A dropped write beats a simultaneous clear.
            if (serialWE && full_q)
                ovf_q <= 1'b1;
            else if (clearOverflow)
                ovf_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        shift_q <= head;
                        baud_q  <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_q == IW'(W - 1)) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q   <= bit_q + IW'(1);
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q <= head;
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign txOut     = tx_q;
    assign busy      = busy_q;
    assign fifoFull  = full_q;
    assign fifoCount = count_q;
    assign overflow  = ovf_q;

endmodule
